// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin write arbiter feeding the single write port of Sync_FIFO
module fifo_wr_arbiter #(
    parameter int NREQ       = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BUF_WIDTH  = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ*DATA_WIDTH-1:0] req_data,
    output logic [NREQ-1:0]            gnt,
    output logic                       wr_en,
    output logic [DATA_WIDTH-1:0]      buf_in,
    input  logic [BUF_WIDTH:0]         fifo_counter,
    input  logic                       buf_full,
    output logic                       ovf_err
);

    localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = BUF_WIDTH + 2;
    localparam logic [CW-1:0] DEPTH = CW'(1) << BUF_WIDTH;

    logic [NREQ-1:0]       gnt_q, gnt_d;
    logic                  wr_en_q, wr_en_d;
    logic [DATA_WIDTH-1:0] buf_in_q, buf_in_d;
    logic [LW-1:0]         last_q, last_d;
    logic                  ovf_q, ovf_d;

    logic [NREQ-1:0]       elig;
    logic [CW-1:0]         committed;
    logic                  space_ok;
    logic                  found;
    logic [LW-1:0]         win;
    logic [LW:0]           cand;

    // A producer granted this cycle still shows the word just taken, so mask it.
    assign elig      = req & ~gnt_q;
    // The write in flight commits at the coming edge; reads are deliberately ignored.
    assign committed = CW'(fifo_counter) + CW'(wr_en_q);
    assign space_ok  = committed < DEPTH;

    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = {1'b0, last_q} + (LW+1)'(k);
            if (cand >= (LW+1)'(NREQ)) begin
                cand = cand - (LW+1)'(NREQ);
            end
            if (!found && elig[cand[LW-1:0]]) begin
                found = 1'b1;
                win   = cand[LW-1:0];
            end
        end
    end

    always_comb begin
        gnt_d    = '0;
        wr_en_d  = 1'b0;
        buf_in_d = buf_in_q;
        last_d   = last_q;
        ovf_d    = ovf_q | (wr_en_q & buf_full);
        if (found && space_ok) begin
            gnt_d    = {{(NREQ-1){1'b0}}, 1'b1} << win;
            wr_en_d  = 1'b1;
            buf_in_d = req_data[win*DATA_WIDTH +: DATA_WIDTH];
            last_d   = win;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q    <= '0;
            wr_en_q  <= 1'b0;
            buf_in_q <= '0;
            last_q   <= LW'(NREQ - 1);
            ovf_q    <= 1'b0;
        end else begin
            gnt_q    <= gnt_d;
            wr_en_q  <= wr_en_d;
            buf_in_q <= buf_in_d;
            last_q   <= last_d;
            ovf_q    <= ovf_d;
        end
    end

    assign gnt     = gnt_q;
    assign wr_en   = wr_en_q;
    assign buf_in  = buf_in_q;
    assign ovf_err = ovf_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter with a Sync_FIFO model
module tb_fifo_wr_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int BW   = 3;
    localparam int DEP  = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NREQ-1:0] req = '0;
    logic [DW-1:0]   dat [NREQ];
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0] gnt;
    logic            wr_en;
    logic [DW-1:0]   buf_in;
    logic [BW:0]     cnt;
    logic            buf_full;
    logic            ovf_err;
    logic            rd_en = 1'b0;

    int checks = 0;
    int errs   = 0;

    always #5 clk = ~clk;

    assign req_data = {dat[3], dat[2], dat[1], dat[0]};
    assign buf_full = (cnt == 4'(DEP));

    fifo_wr_arbiter #(.NREQ(NREQ), .DATA_WIDTH(DW), .BUF_WIDTH(BW)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
        .wr_en(wr_en), .buf_in(buf_in), .fifo_counter(cnt), .buf_full(buf_full),
        .ovf_err(ovf_err)
    );

    // Sync_FIFO stand-in: storage as a queue, counter exposed after the edge.
    logic [DW-1:0] fq[$];
    bit f_full, f_empty;
    always @(posedge clk) begin
        if (rst) begin
            fq.delete();
            cnt <= '0;
        end else begin
            f_full  = (fq.size() == DEP);
            f_empty = (fq.size() == 0);
            if (rd_en && !f_empty) void'(fq.pop_front());
            if (wr_en && !f_full) fq.push_back(buf_in);
            cnt <= 4'(fq.size());
        end
    end

    // Reference arbiter: rotate from the last winner, skip the producer just granted.
    function automatic int pick(input logic [3:0] r, input logic [3:0] g, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            int i = (last + k) % NREQ;
            if (r[i] && !g[i]) return i;
        end
        return -1;
    endfunction

    logic [3:0]    m_gnt;
    logic          m_wr;
    logic [DW-1:0] m_buf;
    logic          m_ovf;
    int            m_last;
    int            w;
    always @(posedge clk) begin
        if (rst) begin
            m_gnt <= '0; m_wr <= 1'b0; m_buf <= '0; m_ovf <= 1'b0; m_last <= NREQ - 1;
        end else begin
            m_ovf <= m_ovf | (m_wr & (cnt == 4'(DEP)));
            w = pick(req, m_gnt, m_last);
            if (w >= 0 && (DEP - int'(cnt) - int'(m_wr)) > 0) begin
                m_gnt <= 4'b0001 << w; m_wr <= 1'b1; m_buf <= dat[w]; m_last <= w;
            end else begin
                m_gnt <= '0; m_wr <= 1'b0;
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("model_gnt", 32'(gnt), 32'(m_gnt));
        check("model_wr", 32'(wr_en), 32'(m_wr));
        check("model_buf", 32'(buf_in), 32'(m_buf));
        check("model_ovf", 32'(ovf_err), 32'(m_ovf));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) step();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [3:0] req_v;
        logic [3:0] gnt_v;
        logic       wr_v;
        logic [7:0] buf_v;
    } vec_t;
    vec_t tbl[10];

    logic [7:0] rot_exp[8];
    logic [3:0] fair_exp[4];

    initial begin
        for (int i = 0; i < 8; i++) begin
            tbl[i] = '{4'b1111, 4'b0001 << (i % 4), 1'b1, 8'(10 * ((i % 4) + 1))};
            rot_exp[i] = 8'(10 * ((i % 4) + 1));
        end
        tbl[8] = '{4'b1111, 4'b0000, 1'b0, 8'd40};
        tbl[9] = '{4'b1111, 4'b0000, 1'b0, 8'd40};
        fair_exp = '{4'b0100, 4'b0001, 4'b0100, 4'b0001};
        for (int i = 0; i < NREQ; i++) dat[i] = 8'(10 * (i + 1));

        // Reset held with every producer requesting
        req = 4'b1111;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_gnt", 32'(gnt), 0);
            check("rst_wr", 32'(wr_en), 0);
            check("rst_buf", 32'(buf_in), 0);
            check("rst_ovf", 32'(ovf_err), 0);
        end
        rst = 1'b0;

        // Rotation until full
        for (int i = 0; i < 10; i++) begin
            req = tbl[i].req_v;
            step();
            check("rot_gnt", 32'(gnt), 32'(tbl[i].gnt_v));
            check("rot_wr", 32'(wr_en), 32'(tbl[i].wr_v));
            check("rot_buf", 32'(buf_in), 32'(tbl[i].buf_v));
        end
        check("rot_cnt", 32'(cnt), 8);
        check("rot_size", fq.size(), 8);
        for (int i = 0; i < 8 && i < fq.size(); i++) check("rot_fifo", 32'(fq[i]), 32'(rot_exp[i]));
        check("rot_ovf", 32'(ovf_err), 0);

        // Full back-pressure then one pop
        req = 4'b0100;
        dat[2] = 8'd140;
        step(); check("full_gnt0", 32'(gnt), 0);
        step(); check("full_gnt1", 32'(gnt), 0);
        rd_en = 1'b1;
        step(); check("full_gnt2", 32'(gnt), 0);
        rd_en = 1'b0;
        step(); check("bp_gnt", 32'(gnt), 32'(4'b0100));
        check("bp_buf", 32'(buf_in), 140);
        req = 4'b0000;
        step(); check("bp_gnt_off", 32'(gnt), 0);
        check("bp_cnt", 32'(cnt), 8);
        if (fq.size() == 8) begin
            check("bp_head", 32'(fq[0]), 20);
            check("bp_tail", 32'(fq[7]), 140);
        end else check("bp_size", fq.size(), 8);
        check("bp_ovf", 32'(ovf_err), 0);

        // Lone requester with changing data
        do_reset(2);
        req = 4'b0010;
        dat[1] = 8'd1;
        for (int n = 1; n <= 3; n++) begin
            step();
            check("single_gnt", 32'(gnt), 32'(4'b0010));
            check("single_buf", 32'(buf_in), n);
            if (n < 3) dat[1] = 8'(n + 1); else req = 4'b0000;
            step();
            check("single_gap", 32'(gnt), 0);
        end
        step();
        check("single_size", fq.size(), 3);
        for (int i = 0; i < 3 && i < fq.size(); i++) check("single_fifo", 32'(fq[i]), i + 1);

        // Fairness skip over idle producers
        do_reset(2);
        dat[0] = 8'd5;
        dat[2] = 8'd7;
        req = 4'b0101;
        step();
        check("fair_first", 32'(gnt), 32'(4'b0001));
        for (int i = 0; i < 4; i++) begin
            step();
            check("fair_gnt", 32'(gnt), 32'(fair_exp[i]));
        end
        req = 4'b0000;

        // Reset while a write is in flight
        do_reset(2);
        for (int i = 0; i < NREQ; i++) dat[i] = 8'(10 * (i + 1));
        req = 4'b1111;
        repeat (6) step();
        check("mid_wr_pre", 32'(wr_en), 1);
        check("mid_cnt_pre", 32'(cnt), 5);
        rst = 1'b1;
        step();
        check("mid_wr", 32'(wr_en), 0);
        check("mid_gnt", 32'(gnt), 0);
        check("mid_buf", 32'(buf_in), 0);
        check("mid_cnt", 32'(cnt), 0);
        rst = 1'b0;
        step();
        check("mid_restart", 32'(gnt), 32'(4'b0001));
        req = 4'b0000;

        // Random traffic against the reference model
        do_reset(2);
        for (int c = 0; c < 600; c++) begin
            req = 4'($urandom_range(0, 15));
            for (int i = 0; i < NREQ; i++) dat[i] = 8'($urandom);
            rd_en = ($urandom_range(0, 3) == 0);
            step();
        end
        rd_en = 1'b0;
        req = 4'b0000;
        step();
        check("rand_ovf", 32'(ovf_err), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
